// File: rtl/cpu_nios2_gen2_0_cpu_debug_ocimem.sv
// Debug OCI RAM controller: JTAG word reads/writes with auto-increment through
// MonAReg/MonDReg, plus a CPU port sharing the same single-port RAM.
module cpu_nios2_gen2_0_cpu_debug_ocimem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP, WR_DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] mon_areg;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_wdata;
    logic              jdo_rd;
    logic [31:0]       ram [0:DEPTH-1];
    logic [31:0]       ram_q;
    logic              rd_oob;
    logic              cpu_pending;
    logic              load_addr;
    logic              clear_err;
    logic              set_err;
    logic              jtag_wr;
    logic              jtag_rd;
    logic              capture;
    logic              jtag_owns;
    logic              cpu_rd_issue;
    logic              cpu_wr_en;
    logic              unused_jdo;

    assign jdo_addr   = jdo[17+ADDR_W-1:17];
    assign jdo_wdata  = jdo[34:3];
    assign jdo_rd     = jdo[34];
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {{(32-ADDR_W){1'b0}}, a} < DEPTH_U;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are only honoured in IDLE; anywhere else they are dropped and flagged.
    always_comb begin
        next_state = state;
        load_addr  = 1'b0;
        clear_err  = 1'b0;
        set_err    = 1'b0;
        jtag_wr    = 1'b0;
        jtag_rd    = 1'b0;
        capture    = 1'b0;
        jtag_owns  = 1'b0;
        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    load_addr = 1'b1;
                    clear_err = 1'b1;
                    if (jdo_rd) begin
                        next_state = RD_ISSUE;
                    end
                end else if (take_action_ocimem_b) begin
                    jtag_owns  = 1'b1;
                    next_state = WR_DONE;
                    if (in_range(mon_areg)) begin
                        jtag_wr = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    next_state = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                jtag_owns  = 1'b1;
                next_state = RD_CAP;
                if (in_range(mon_areg)) begin
                    jtag_rd = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
            end
            RD_CAP: begin
                capture    = !rd_oob;
                next_state = IDLE;
            end
            WR_DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (state != IDLE &&
            (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a)) begin
            set_err = 1'b1;
        end
    end

    // CPU reads take one wait cycle to issue; the pending flag marks the data cycle.
    always_comb begin
        cpu_wr_en    = cpu_write && !jtag_owns && in_range(cpu_address);
        cpu_rd_issue = cpu_read && !cpu_write && !cpu_pending && !jtag_owns;
        if (cpu_write) begin
            cpu_waitrequest = jtag_owns;
        end else begin
            cpu_waitrequest = cpu_read && !cpu_pending;
        end
    end

    assign monitor_ready = (state == IDLE);
    assign cpu_readdata  = ram_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mon_areg      <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
            ram_q         <= '0;
            rd_oob        <= 1'b0;
            cpu_pending   <= 1'b0;
        end else begin
            if (load_addr) begin
                mon_areg <= jdo_addr;
            end else if (jtag_wr || capture) begin
                mon_areg <= mon_areg + 1'b1;
            end
            if (capture) begin
                MonDReg <= ram_q;
            end
            if (set_err) begin
                monitor_error <= 1'b1;
            end else if (clear_err) begin
                monitor_error <= 1'b0;
            end
            rd_oob      <= (state == RD_ISSUE) && !in_range(mon_areg);
            cpu_pending <= cpu_rd_issue;
            // One shared read port: JTAG and CPU reads never issue on the same edge.
            if (jtag_rd) begin
                ram_q <= ram[mon_areg];
            end else if (cpu_rd_issue) begin
                ram_q <= in_range(cpu_address) ? ram[cpu_address] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (jtag_wr) begin
                ram[mon_areg] <= jdo_wdata;
            end else if (cpu_wr_en) begin
                ram[cpu_address] <= cpu_writedata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_nios2_gen2_0_cpu_debug_ocimem.sv
// Randomized bench for the OCI RAM controller: a full-depth and a DEPTH=200
// instance share stimulus and are checked against a word-level memory model.
module tb_cpu_nios2_gen2_0_cpu_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;

    wire [1:0][31:0] rdata;
    wire [1:0][31:0] dreg;
    wire [1:0]       wreq;
    wire [1:0]       ready;
    wire [1:0]       err;

    always #5 clk = ~clk;

    cpu_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(8), .DEPTH(256)) dut_full (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(rdata[0]),
        .cpu_waitrequest(wreq[0]), .MonDReg(dreg[0]),
        .monitor_ready(ready[0]), .monitor_error(err[0])
    );

    cpu_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(8), .DEPTH(200)) dut_small (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(rdata[1]),
        .cpu_waitrequest(wreq[1]), .MonDReg(dreg[1]),
        .monitor_ready(ready[1]), .monitor_error(err[1])
    );

    int          depth [2] = '{256, 200};
    logic [31:0] m_mem [2][256];
    logic [7:0]  m_addr [2];
    logic [31:0] m_dreg [2];
    logic        m_err [2];
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic modelRead(input int d);
        if (int'(m_addr[d]) < depth[d]) begin
            m_dreg[d] = m_mem[d][m_addr[d]];
            m_addr[d] = m_addr[d] + 8'd1;
        end else begin
            m_err[d] = 1'b1;
        end
    endtask

    task automatic modelWrite(input int d, input logic [31:0] data);
        if (int'(m_addr[d]) < depth[d]) begin
            m_mem[d][m_addr[d]] = data;
            m_addr[d] = m_addr[d] + 8'd1;
        end else begin
            m_err[d] = 1'b1;
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = 8'd0;
            m_dreg[d] = 32'd0;
            m_err[d]  = 1'b0;
        end
    endtask

    function automatic logic [37:0] mkLoad(input logic [7:0] addr, input logic rd);
        logic [37:0] v;
        v = {6'($urandom), $urandom};
        v[24:17] = addr;
        v[34] = rd;
        return v;
    endfunction

    function automatic logic [37:0] mkWrite(input logic [31:0] data);
        logic [37:0] v;
        v = {6'($urandom), $urandom};
        v[34:3] = data;
        return v;
    endfunction

    task automatic checkState(input string tag, input logic exp_ready);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s ready[%0d]", tag, d), 32'(ready[d]), 32'(exp_ready));
            if (exp_ready) begin
                checkOutput($sformatf("%s MonDReg[%0d]", tag, d), dreg[d], m_dreg[d]);
                checkOutput($sformatf("%s error[%0d]", tag, d), 32'(err[d]), 32'(m_err[d]));
            end
        end
    endtask

    // One JTAG transaction; ready must drop for exactly the documented latency.
    task automatic applyStimulus(input logic a, input logic b, input logic n,
                                 input logic [37:0] jv, input logic poke, input string tag);
        int lat;
        for (int d = 0; d < 2; d++) begin
            if (a) begin
                m_addr[d] = jv[24:17];
                m_err[d]  = 1'b0;
                if (jv[34]) modelRead(d);
            end else if (b) begin
                modelWrite(d, jv[34:3]);
            end else if (n) begin
                modelRead(d);
            end
        end
        lat = a ? (jv[34] ? 3 : 1) : b ? 2 : n ? 3 : 1;
        jdo = jv;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        step();
        clearStrobes();
        for (int k = 1; k < lat; k++) begin
            checkState($sformatf("%s busy%0d", tag, k), 1'b0);
            if (poke && k == 1) begin
                case ($urandom_range(0, 2))
                    0: take_action_ocimem_a = 1'b1;
                    1: take_action_ocimem_b = 1'b1;
                    default: take_no_action_ocimem_a = 1'b1;
                endcase
                m_err[0] = 1'b1;
                m_err[1] = 1'b1;
            end
            step();
            clearStrobes();
        end
        checkState($sformatf("%s done", tag), 1'b1);
    endtask

    task automatic cpuRead(input logic [7:0] a, input int exp_waits);
        int waits;
        waits = 0;
        cpu_address = a;
        cpu_read = 1'b1;
        #1;
        while (wreq[0] === 1'b1 && waits < 8) begin
            step();
            waits++;
        end
        if (exp_waits >= 0) checkOutput("cpu waits", 32'(waits), 32'(exp_waits));
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("cpu rd wait[%0d]", d), 32'(wreq[d]), 32'd0);
            checkOutput($sformatf("cpu rdata[%0d] @%0h", d, a), rdata[d],
                        (int'(a) < depth[d]) ? m_mem[d][a] : 32'd0);
        end
        step();
        cpu_read = 1'b0;
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [31:0] data);
        cpu_address = a;
        cpu_writedata = data;
        cpu_write = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("cpu wr wait[%0d]", d), 32'(wreq[d]), 32'd0);
            if (int'(a) < depth[d]) m_mem[d][a] = data;
        end
        step();
        cpu_write = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [37:0] jv;
        logic [31:0] old;
        logic [2:0]  bits;
        reset_n = 1'b0;
        jdo = '0;
        clearStrobes();
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        modelReset();

        step();
        step();
        checkState("reset", 1'b1);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset wait[%0d]", d), 32'(wreq[d]), 32'd0);
            checkOutput($sformatf("reset rdata[%0d]", d), rdata[d], 32'd0);
        end
        reset_n = 1'b1;

        // Fill every word so later reads have known contents.
        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h00, 1'b0), 1'b0, "fill load");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, mkWrite($urandom), 1'b0, "fill");
        end

        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h10, 1'b0), 1'b0, "t2 load");
        applyStimulus(1'b0, 1'b1, 1'b0, mkWrite(32'hCAFEF00D), 1'b0, "t2 write");
        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h10, 1'b1), 1'b0, "t2 readback");
        checkOutput("t2 const", dreg[0], 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b0, 1'b1, 38'd0, 1'b0, "t2 next");

        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'hFE, 1'b0), 1'b0, "t3 load");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, mkWrite(32'(i)), 1'b0, "t3 write");
        end
        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'hFE, 1'b1), 1'b0, "t3 rd");
        checkOutput("t3 const 0xFE", dreg[0], 32'd1);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 38'd0, 1'b0, "t3 rd");
            checkOutput("t3 const wrap", dreg[0], 32'(i));
        end

        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'd200, 1'b1), 1'b0, "t4 oob");
        checkOutput("t4 error small", 32'(err[1]), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'd0, 1'b0), 1'b0, "t4 clear");
        checkOutput("t4 cleared small", 32'(err[1]), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h30, 1'b0), 1'b0, "t5 load");
        for (int d = 0; d < 2; d++) modelRead(d);
        take_no_action_ocimem_a = 1'b1;
        step();
        clearStrobes();
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("t5 wait issue[%0d]", d), 32'(wreq[d]), 32'd1);
        take_no_action_ocimem_a = 1'b1;
        m_err[0] = 1'b1;
        m_err[1] = 1'b1;
        step();
        clearStrobes();
        for (int d = 0; d < 2; d++) checkOutput($sformatf("t5 wait cap[%0d]", d), 32'(wreq[d]), 32'd1);
        checkState("t5 cap", 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("t5 wait done[%0d]", d), 32'(wreq[d]), 32'd0);
            checkOutput($sformatf("t5 rdata[%0d]", d), rdata[d], m_mem[d][8'h20]);
        end
        checkState("t5 done", 1'b1);
        step();
        cpu_read = 1'b0;

        for (int it = 0; it < 150; it++) begin
            logic poke;
            poke = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'($urandom), 1'($urandom)), poke, "rnd load");
                1, 2: applyStimulus(1'b0, 1'b1, 1'b0, mkWrite($urandom), poke, "rnd write");
                3: applyStimulus(1'b0, 1'b0, 1'b1, mkLoad(8'($urandom), 1'($urandom)), poke, "rnd read");
                4: begin
                    bits = 3'($urandom_range(1, 7));
                    applyStimulus(bits[2], bits[1], bits[0], mkLoad(8'($urandom), 1'($urandom)), poke, "rnd multi");
                end
                5: cpuRead(8'($urandom), 1);
                6: cpuWrite(8'($urandom), $urandom);
                default: applyStimulus(1'b0, 1'b0, 1'b1, 38'd0, 1'b1, "rnd poke");
            endcase
        end

        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h40, 1'b0), 1'b0, "t6 load");
        take_no_action_ocimem_a = 1'b1;
        step();
        clearStrobes();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        modelReset();
        checkState("t6 reset", 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h40, 1'b1), 1'b0, "t6 ram kept");

        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h50, 1'b0), 1'b0, "t6 load2");
        old = m_mem[0][8'h50];
        jv = mkWrite(~old);
        jdo = jv;
        take_action_ocimem_b = 1'b1;
        reset_n = 1'b0;
        step();
        clearStrobes();
        reset_n = 1'b1;
        modelReset();
        checkState("t6 wr reset", 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, mkLoad(8'h50, 1'b1), 1'b0, "t6 no write");
        checkOutput("t6 word kept", dreg[0], old);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
